// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared constants, FSM state type and priority helper for the 8259 INTA sequencer
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam int ID_W   = 3;
  localparam logic [ID_W-1:0] SPUR_ID = 3'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK2_WAIT = 2'd1,
    DRIVE     = 2'd2
  } inta_state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } prio_t;

  // Lowest set bit wins: IR0 is the highest priority level.
  function automatic prio_t lowest_set(input logic [NUM_IR-1:0] v);
    prio_t r;
    r.valid = 1'b0;
    r.id    = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.id    = ID_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// rtl/pic_inta_sequencer_if.sv - request, acknowledge and vector bus bundle of the INTA sequencer
interface pic_inta_sequencer_if;
  import pic_pkg::*;

  logic [NUM_IR-1:0] ir_req;
  logic [NUM_IR-1:0] imr;
  logic [4:0]        vec_base;
  logic [NUM_IR-1:0] slave_map;
  logic              sngl;
  logic              sp;
  logic              vec_en;
  logic              inta_n;
  logic              eoi_valid;
  logic              eoi_specific;
  logic [ID_W-1:0]   eoi_level;
  logic              int_o;
  logic              pulse1;
  logic              pulse2;
  logic [ID_W-1:0]   intr_id;
  logic [NUM_IR-1:0] isr;
  logic [7:0]        data_out;
  logic              data_oe;

  modport master (
    output ir_req, imr, vec_base, slave_map, sngl, sp, vec_en, inta_n,
           eoi_valid, eoi_specific, eoi_level,
    input  int_o, pulse1, pulse2, intr_id, isr, data_out, data_oe
  );

  modport slave (
    input  ir_req, imr, vec_base, slave_map, sngl, sp, vec_en, inta_n,
           eoi_valid, eoi_specific, eoi_level,
    output int_o, pulse1, pulse2, intr_id, isr, data_out, data_oe
  );

endinterface

// File: rtl/pic_priority_resolver.sv
// rtl/pic_priority_resolver.sv - fixed-priority candidate selection against the in-service register
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic [NUM_IR-1:0] isr,
  output logic [ID_W-1:0]   cand,
  output logic              pend
);

  prio_t req_lo;
  prio_t isr_lo;

  // A request only interrupts when it outranks everything already in service.
  always_comb begin
    req_lo = lowest_set(irr & ~imr);
    isr_lo = lowest_set(isr);
    cand   = req_lo.id;
    pend   = req_lo.valid && (!isr_lo.valid || (req_lo.id < isr_lo.id));
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// rtl/pic_inta_sequencer.sv - 8259 IRR/ISR, priority and two-pulse INTA vector sequencer
// Optional build macro PIC_AUTO_EOI_EN: clear the acknowledged ISR bit at the end of the second INTA.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  pic_inta_sequencer_if.slave bus
);

`ifdef PIC_AUTO_EOI_EN
  localparam logic AUTO_EOI = 1'b1;
`else
  localparam logic AUTO_EOI = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ACK2  = 2'(ACK2_WAIT);
  localparam logic [1:0] S_DRIVE = 2'(DRIVE);

  logic [1:0]        state_q, state_d;
  logic              inta_q, inta_d;
  logic [NUM_IR-1:0] ir_req_q, ir_req_d;
  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [ID_W-1:0]   intr_id_q, intr_id_d;
  logic              int_o_q, int_o_d;
  logic              pulse1_q, pulse1_d;
  logic              pulse2_q, pulse2_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;

  logic              fall;
  logic              rise;
  logic [ID_W-1:0]   cand;
  logic              pend;
  prio_t             eoi_lo;

  pic_priority_resolver u_prio (
    .irr  (irr_q),
    .imr  (bus.imr),
    .isr  (isr_q),
    .cand (cand),
    .pend (pend)
  );

  always_comb begin
    state_d    = state_q;
    inta_d     = bus.inta_n;
    ir_req_d   = bus.ir_req;
    intr_id_d  = intr_id_q;
    data_out_d = data_out_q;
    pulse1_d   = 1'b0;
    pulse2_d   = 1'b0;
    data_oe_d  = 1'b0;
    fall       = inta_q & ~bus.inta_n;
    rise       = ~inta_q & bus.inta_n;

    irr_d = (irr_q | (bus.ir_req & ~ir_req_q)) & bus.ir_req;

    // EOI is applied before the acknowledge set so a same-bit set wins.
    isr_d  = isr_q;
    eoi_lo = lowest_set(isr_q);
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        isr_d[bus.eoi_level] = 1'b0;
      end else if (eoi_lo.valid) begin
        isr_d[eoi_lo.id] = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          pulse1_d = 1'b1;
          state_d  = S_ACK2;
          if (pend) begin
            intr_id_d   = cand;
            isr_d[cand] = 1'b1;
            irr_d[cand] = 1'b0;
          end else begin
            intr_id_d = SPUR_ID;
          end
        end
      end
      S_ACK2: begin
        if (fall) begin
          pulse2_d   = 1'b1;
          data_out_d = {bus.vec_base, intr_id_q};
          state_d    = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (rise) begin
          state_d = S_IDLE;
          if (AUTO_EOI) begin
            isr_d[intr_id_q] = 1'b0;
          end
        end else begin
          data_oe_d = bus.sngl
                    | (bus.sp & ~bus.slave_map[intr_id_q])
                    | (~bus.sp & bus.vec_en);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Held low for the whole acknowledge sequence, resampled once back in IDLE.
    int_o_d = (state_q == S_IDLE) && (state_d == S_IDLE) && pend;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      inta_q     <= 1'b1;
      ir_req_q   <= '0;
      irr_q      <= '0;
      isr_q      <= '0;
      intr_id_q  <= '0;
      int_o_q    <= 1'b0;
      pulse1_q   <= 1'b0;
      pulse2_q   <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inta_q     <= inta_d;
      ir_req_q   <= ir_req_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      intr_id_q  <= intr_id_d;
      int_o_q    <= int_o_d;
      pulse1_q   <= pulse1_d;
      pulse2_q   <= pulse2_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign bus.int_o    = int_o_q;
  assign bus.pulse1   = pulse1_q;
  assign bus.pulse2   = pulse2_q;
  assign bus.intr_id  = intr_id_q;
  assign bus.isr      = isr_q;
  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb/tb_pic_inta_sequencer.sv - vector table plus scoreboard bench for pic_inta_sequencer
module tb_pic_inta_sequencer;
  import pic_pkg::*;

`ifdef PIC_AUTO_EOI_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pic_inta_sequencer_if bus();

  pic_inta_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       is_p2;
    logic [2:0] id;
    logic [7:0] isr;
    logic [7:0] data;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       has_req;
    logic [2:0] line;
    logic [7:0] imr;
    logic       sngl;
    logic       sp;
    logic [7:0] smap;
    logic       vec_en;
    logic [4:0] base;
    logic       exp_int;
    logic [2:0] exp_id;
    logic [7:0] exp_isr;
    logic [7:0] exp_data;
    logic       exp_oe;
  } vec_t;
  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.ir_req    = '0;
    bus.inta_n    = 1'b1;
    bus.eoi_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic do_inta(input logic [2:0] id, input logic [7:0] isr_p1, input logic [7:0] data,
                         input logic exp_oe, input logic [7:0] isr_end, input logic eoi_on_fall,
                         input string tag);
    sb.push_back('{1'b0, id, isr_p1, 8'h00});
    bus.inta_n = 1'b0;
    if (eoi_on_fall) begin
      bus.eoi_valid    = 1'b1;
      bus.eoi_specific = 1'b0;
    end
    tick();
    bus.eoi_valid = 1'b0;
    bus.inta_n    = 1'b1;
    tick(2);
    check({tag, "_int_o_in_ack"}, 32'(bus.int_o), 32'd0);
    sb.push_back('{1'b1, id, 8'h00, data});
    bus.inta_n = 1'b0;
    tick();
    check({tag, "_oe_at_pulse2"}, 32'(bus.data_oe), 32'd0);
    tick();
    check({tag, "_oe_drive"}, 32'(bus.data_oe), 32'(exp_oe));
    tick();
    check({tag, "_oe_held"}, 32'(bus.data_oe), 32'(exp_oe));
    bus.inta_n = 1'b1;
    tick();
    check({tag, "_oe_after_rise"}, 32'(bus.data_oe), 32'd0);
    check({tag, "_isr_end"}, 32'(bus.isr), 32'(isr_end));
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && (bus.pulse1 || bus.pulse2)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("sb_pulse_kind", 32'(bus.pulse2), 32'(e.is_p2));
        check("sb_intr_id", 32'(bus.intr_id), 32'(e.id));
        if (e.is_p2) check("sb_data_out", 32'(bus.data_out), 32'(e.data));
        else         check("sb_isr_at_pulse1", 32'(bus.isr), 32'(e.isr));
      end
    end
  end

  initial begin
    bus.ir_req       = '0;
    bus.imr          = '0;
    bus.vec_base     = 5'h08;
    bus.slave_map    = '0;
    bus.sngl         = 1'b1;
    bus.sp           = 1'b1;
    bus.vec_en       = 1'b0;
    bus.inta_n       = 1'b1;
    bus.eoi_valid    = 1'b0;
    bus.eoi_specific = 1'b0;
    bus.eoi_level    = '0;

    vt[0] = '{1'b1, 3'd3, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 5'h08, 1'b1, 3'd3, 8'h08, 8'h43, 1'b1};
    vt[1] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 5'h08, 1'b0, 3'd7, 8'h00, 8'h47, 1'b1};
    vt[2] = '{1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 5'h08, 1'b1, 3'd2, 8'h04, 8'h42, 1'b0};
    vt[3] = '{1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 5'h08, 1'b1, 3'd2, 8'h04, 8'h42, 1'b1};
    vt[4] = '{1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 5'h10, 1'b1, 3'd2, 8'h04, 8'h82, 1'b0};
    vt[5] = '{1'b1, 3'd6, 8'h40, 1'b1, 1'b1, 8'h00, 1'b0, 5'h08, 1'b0, 3'd7, 8'h00, 8'h47, 1'b1};
    vt[6] = '{1'b1, 3'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 5'h1F, 1'b1, 3'd0, 8'h01, 8'hF8, 1'b1};
    vt[7] = '{1'b1, 3'd5, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 5'h03, 1'b1, 3'd5, 8'h20, 8'h1D, 1'b1};

    do_reset();
    check("rst_int_o",    32'(bus.int_o),    32'd0);
    check("rst_pulse1",   32'(bus.pulse1),   32'd0);
    check("rst_pulse2",   32'(bus.pulse2),   32'd0);
    check("rst_intr_id",  32'(bus.intr_id),  32'd0);
    check("rst_isr",      32'(bus.isr),      32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_data_oe",  32'(bus.data_oe),  32'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.imr       = vt[i].imr;
      bus.sngl      = vt[i].sngl;
      bus.sp        = vt[i].sp;
      bus.slave_map = vt[i].smap;
      bus.vec_en    = vt[i].vec_en;
      bus.vec_base  = vt[i].base;
      if (vt[i].has_req) bus.ir_req = 8'h01 << vt[i].line;
      tick(3);
      check($sformatf("vec%0d_int_o", i), 32'(bus.int_o), 32'(vt[i].exp_int));
      do_inta(vt[i].exp_id, vt[i].exp_isr, vt[i].exp_data, vt[i].exp_oe,
              AUTO ? 8'h00 : vt[i].exp_isr, 1'b0, $sformatf("vec%0d", i));
      bus.ir_req = '0;
      tick();
    end

    // Nested priority: a lower level waits behind the in-service level, a higher one does not.
    do_reset();
    bus.imr = '0; bus.sngl = 1'b1; bus.sp = 1'b1; bus.vec_base = 5'h08;
    bus.ir_req = 8'h20;
    tick(3);
    do_inta(3'd5, 8'h20, 8'h45, 1'b1, AUTO ? 8'h00 : 8'h20, 1'b0, "prio_ack5");
    bus.ir_req = 8'h00;
    tick();
    bus.ir_req = 8'h40;
    tick(3);
    check("prio_lower_blocked", 32'(bus.int_o), 32'(AUTO));
    bus.ir_req = 8'h44;
    tick(3);
    check("prio_higher_int", 32'(bus.int_o), 32'd1);
    bus.eoi_valid = 1'b1; bus.eoi_specific = 1'b1; bus.eoi_level = 3'd5;
    tick();
    bus.eoi_valid = 1'b0;
    check("prio_specific_eoi", 32'(bus.isr), 32'd0);
    bus.ir_req = 8'h40;
    tick(3);
    check("prio_lower_after_eoi", 32'(bus.int_o), 32'd1);

    do_reset();
    bus.ir_req = 8'h20;
    tick(3);
`ifdef PIC_AUTO_EOI_EN
    do_inta(3'd5, 8'h20, 8'h45, 1'b1, 8'h00, 1'b0, "auto_eoi");
`else
    do_inta(3'd5, 8'h20, 8'h45, 1'b1, 8'h20, 1'b0, "eoi_ack5");
    bus.ir_req = 8'h28;
    tick(3);
    check("eoi_ir3_int", 32'(bus.int_o), 32'd1);
    do_inta(3'd3, 8'h28, 8'h43, 1'b1, 8'h28, 1'b0, "eoi_ack3");
    bus.ir_req = 8'h00;
    bus.eoi_valid = 1'b1; bus.eoi_specific = 1'b0;
    tick();
    check("eoi_nonspecific", 32'(bus.isr), 32'h20);
    bus.eoi_specific = 1'b1; bus.eoi_level = 3'd5;
    tick();
    check("eoi_specific5", 32'(bus.isr), 32'h00);
    bus.eoi_specific = 1'b0;
    tick();
    bus.eoi_valid = 1'b0;
    check("eoi_empty_noop", 32'(bus.isr), 32'h00);
    bus.ir_req = 8'h20;
    tick(3);
    do_inta(3'd5, 8'h20, 8'h45, 1'b1, 8'h20, 1'b0, "same_ack5");
    bus.ir_req = 8'h28;
    tick(3);
    do_inta(3'd3, 8'h08, 8'h43, 1'b1, 8'h08, 1'b1, "same_cycle_eoi");
`endif
    bus.ir_req = '0;
    tick();

    // Reset while waiting for the second INTA abandons the sequence.
    do_reset();
    bus.ir_req = 8'h08;
    tick(3);
    sb.push_back('{1'b0, 3'd3, 8'h08, 8'h00});
    bus.inta_n = 1'b0;
    tick();
    bus.inta_n = 1'b1;
    tick();
    rst_n = 1'b0;
    bus.ir_req = '0;
    tick();
    check("midrst_int_o",    32'(bus.int_o),    32'd0);
    check("midrst_pulse1",   32'(bus.pulse1),   32'd0);
    check("midrst_pulse2",   32'(bus.pulse2),   32'd0);
    check("midrst_isr",      32'(bus.isr),      32'd0);
    check("midrst_intr_id",  32'(bus.intr_id),  32'd0);
    check("midrst_data_out", 32'(bus.data_out), 32'd0);
    check("midrst_data_oe",  32'(bus.data_oe),  32'd0);
    rst_n = 1'b1;
    tick();
    sb.push_back('{1'b0, 3'd7, 8'h00, 8'h00});
    bus.inta_n = 1'b0;
    tick();
    check("midrst_no_pulse2", 32'(bus.pulse2), 32'd0);
    tick(2);
    check("midrst_no_vector", 32'(bus.data_oe), 32'd0);
    bus.inta_n = 1'b1;
    tick(3);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
